// File: rtl/jtframe_z80_busarb_pkg.sv
// Shared types and constants for the Z80 / DMA RAM bus arbiter.
package jtframe_z80_busarb_pkg;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_GRANT   = 3'd2,
        ST_RELEASE = 3'd3,
        ST_HOLDOFF = 3'd4
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/jtframe_z80_busarb.sv
// Shares the Z80 local RAM with one DMA port using the BUSRQ_n/BUSAK_n handshake,
// with burst cap, CPU run gap between grants and a sticky handshake timeout flag.
//
// state   | meaning
// IDLE    | CPU owns RAM, no request pending
// REQ     | busrq_n asserted, waiting for busak_n (timeout counted)
// GRANT   | DMA owns RAM (burst counted)
// RELEASE | busrq_n released, waiting for busak_n to return high
// HOLDOFF | CPU run gap before the next request may be honoured
module jtframe_z80_busarb
    import jtframe_z80_busarb_pkg::*;
#(
    parameter int AW       = 12,
    parameter int DW       = 8,
    parameter int MAXBURST = 64,
    parameter int GAP      = 16,
    parameter int TIMEOUT  = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    output logic          busrq_n,
    input  logic          busak_n,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_dout,
    input  logic          cpu_we,
    input  logic          dma_req,
    output logic          dma_gnt,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_dout,
    input  logic          dma_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    output logic          timeout_err
);

    localparam logic [CNT_W-1:0] MAXBURST_C = CNT_W'(MAXBURST);
    localparam logic [CNT_W-1:0] GAP_C      = CNT_W'(GAP);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             err_q, err_d;
    logic             busrq_n_q, busrq_n_d;
    logic             gnt_q, gnt_d;

    assign cnt_inc = sat_inc(cnt_q);

    // One counter serves timeout, burst and gap: only one is live per state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            busrq_n_q <= 1'b1;
            gnt_q     <= 1'b0;
        end else if (cen) begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            busrq_n_q <= busrq_n_d;
            gnt_q     <= gnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (dma_req) state_d = ST_REQ;
            end
            ST_REQ: begin
                cnt_d = cnt_inc;
                // An ack wins over a simultaneous timeout.
                if (!busak_n) begin
                    state_d = ST_GRANT;
                    cnt_d   = '0;
                end else if (!dma_req) begin
                    state_d = ST_RELEASE;
                end else if (cnt_inc >= TIMEOUT_C) begin
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end
            end
            ST_GRANT: begin
                cnt_d = cnt_inc;
                if (busak_n || !dma_req || cnt_inc >= MAXBURST_C) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                cnt_d = '0;
                if (busak_n) state_d = (GAP == 0) ? ST_IDLE : ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                cnt_d = cnt_inc;
                if (cnt_inc >= GAP_C) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busrq_n_d = !(state_d == ST_REQ || state_d == ST_GRANT);
        gnt_d     = (state_d == ST_GRANT);
        if (gnt_q) begin
            ram_addr = dma_addr;
            ram_din  = dma_dout;
            ram_we   = dma_we;
        end else begin
            ram_addr = cpu_addr;
            ram_din  = cpu_dout;
            // The Z80 is tri-stated while busak_n is low: block its strobe.
            ram_we   = cpu_we & ~((state_q == ST_REQ || state_q == ST_RELEASE) && !busak_n);
        end
    end

    assign busrq_n     = busrq_n_q;
    assign dma_gnt     = gnt_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_jtframe_z80_busarb.sv
// Directed bench for jtframe_z80_busarb with a queue of expected values.
module tb_jtframe_z80_busarb;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst, cen, busak_n, cpu_we, dma_req, dma_we;
    logic [AW-1:0] cpu_addr, dma_addr;
    logic [DW-1:0] cpu_dout, dma_dout;
    logic          busrq_n, dma_gnt, ram_we, timeout_err;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t exp_q[$];

    jtframe_z80_busarb #(
        .AW(AW), .DW(DW), .MAXBURST(4), .GAP(16), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst), .cen(cen),
        .busrq_n(busrq_n), .busak_n(busak_n),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_we(cpu_we),
        .dma_req(dma_req), .dma_gnt(dma_gnt),
        .dma_addr(dma_addr), .dma_dout(dma_dout), .dma_we(dma_we),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: got %0h, required a queued expectation", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: got %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic cyc(input logic c);
        cen = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; busak_n = 1'b1; cpu_we = 1'b0;
        dma_req = 1'b0; dma_we = 1'b0;
        cpu_addr = 12'h3C0; cpu_dout = 8'h11; dma_addr = '0; dma_dout = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset state
        push("rst_busrq_n", 1); push("rst_gnt", 0); push("rst_err", 0); push("rst_ram_addr", 'h3C0);
        pop_check(32'(busrq_n)); pop_check(32'(dma_gnt));
        pop_check(32'(timeout_err)); pop_check(32'(ram_addr));

        // basic grant
        cpu_we = 1'b1; dma_req = 1'b1;
        push("req_busrq_n", 0);
        cyc(1); pop_check(32'(busrq_n));
        cyc(1); cyc(1);
        busak_n = 1'b0;
        push("req_we_blocked", 0); push("gnt_before_ack_edge", 0);
        #1 pop_check(32'(ram_we)); pop_check(32'(dma_gnt));
        push("gnt_after_ack", 1);
        cyc(1); pop_check(32'(dma_gnt));
        dma_addr = 12'h123; dma_dout = 8'hA5; dma_we = 1'b1;
        push("dma_ram_addr", 'h123); push("dma_ram_din", 'hA5); push("dma_ram_we", 1);
        #1 pop_check(32'(ram_addr)); pop_check(32'(ram_din)); pop_check(32'(ram_we));

        // burst cap of 4
        for (int i = 0; i < 3; i++) begin
            push("burst_gnt_hold", 1);
            cyc(1); pop_check(32'(dma_gnt));
        end
        push("burst_gnt_drop", 0); push("burst_busrq_n", 1);
        cyc(1); pop_check(32'(dma_gnt)); pop_check(32'(busrq_n));
        push("rel_we_blocked", 0); push("rel_addr_cpu", 'h3C0);
        pop_check(32'(ram_we)); pop_check(32'(ram_addr));
        busak_n = 1'b1; dma_we = 1'b0;
        push("hold_we_cpu", 1);
        cyc(1); pop_check(32'(ram_we));
        for (int i = 0; i < 16; i++) begin
            push("gap_busrq_n", 1);
            cyc(1); pop_check(32'(busrq_n));
        end
        push("gap_rerequest", 0);
        cyc(1); pop_check(32'(busrq_n));

        // abort in REQ
        dma_req = 1'b0;
        push("abort_busrq_n", 1); push("abort_gnt", 0);
        cyc(1); pop_check(32'(busrq_n)); pop_check(32'(dma_gnt));
        cpu_addr = 12'h010; cpu_dout = 8'h5A; cpu_we = 1'b1;
        push("cpu_ram_addr", 'h010); push("cpu_ram_din", 'h5A); push("cpu_ram_we", 1);
        #1 pop_check(32'(ram_addr)); pop_check(32'(ram_din)); pop_check(32'(ram_we));
        for (int i = 0; i < 17; i++) begin
            push("abort_no_gnt", 0);
            cyc(1); pop_check(32'(dma_gnt));
        end

        // cen gating during GRANT
        dma_req = 1'b1;
        cyc(1);
        busak_n = 1'b0;
        cyc(1);
        push("stall_pre_gnt", 1);
        cyc(1); pop_check(32'(dma_gnt));
        for (int i = 0; i < 10; i++) begin
            if (i == 4) dma_addr = 12'h2AB;
            cyc(0);
        end
        push("stall_gnt", 1); push("stall_busrq_n", 0); push("stall_mux_addr", 'h2AB);
        pop_check(32'(dma_gnt)); pop_check(32'(busrq_n)); pop_check(32'(ram_addr));
        push("resume_gnt_1", 1);
        cyc(1); pop_check(32'(dma_gnt));
        push("resume_gnt_2", 1);
        cyc(1); pop_check(32'(dma_gnt));
        push("resume_gnt_end", 0);
        cyc(1); pop_check(32'(dma_gnt));
        busak_n = 1'b1; dma_req = 1'b0;
        repeat (17) cyc(1);

        // async reset mid-GRANT
        dma_req = 1'b1;
        cyc(1);
        busak_n = 1'b0;
        push("arst_pre_gnt", 1);
        cyc(1); pop_check(32'(dma_gnt));
        @(negedge clk);
        #1 rst = 1'b1;
        push("arst_busrq_n", 1); push("arst_gnt", 0); push("arst_ram_addr", 'h010);
        #1 pop_check(32'(busrq_n)); pop_check(32'(dma_gnt)); pop_check(32'(ram_addr));
        dma_req = 1'b0; busak_n = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // handshake timeout
        dma_req = 1'b1;
        cyc(1);
        for (int i = 0; i < 7; i++) begin
            push("tmo_pending", 0);
            cyc(1); pop_check(32'(timeout_err));
        end
        push("tmo_err", 1); push("tmo_busrq_n", 1);
        cyc(1); pop_check(32'(timeout_err)); pop_check(32'(busrq_n));
        dma_req = 1'b0;
        repeat (20) cyc(1);
        push("tmo_sticky", 1);
        pop_check(32'(timeout_err));
        rst = 1'b1;
        cyc(0);
        rst = 1'b0;
        push("tmo_cleared", 0);
        pop_check(32'(timeout_err));

        // timeout and ack on the same edge: grant wins, no error
        dma_req = 1'b1;
        cyc(1);
        repeat (7) cyc(1);
        busak_n = 1'b0;
        push("race_gnt", 1); push("race_err", 0);
        cyc(1); pop_check(32'(dma_gnt)); pop_check(32'(timeout_err));
        dma_req = 1'b0;
        push("release_gnt", 0); push("release_busrq_n", 1);
        cyc(1); pop_check(32'(dma_gnt)); pop_check(32'(busrq_n));

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jtframe_z80_busarb.md
# jtframe_z80_busarb

Bus arbiter that shares the Z80's local RAM between the Z80 and one DMA requester (sprite/sound-RAM loader, main-CPU bridge). It uses the Z80 BUSRQ_n/BUSAK_n handshake to park the CPU, grants the DMA port, then steers the RAM address, data and write-enable multiplexer to the owner. It sits between the Z80 wrapper (`busrq_n`/`busak_n`, A, dout, RAM write strobe) and the `jtframe_ram` instance. It enforces a maximum burst length and a minimum CPU run gap, and flags handshake timeouts.

## Interface
Parameters:
- `AW`, 12: RAM address width.
- `DW`, 8: data width.
- `MAXBURST`, 64: maximum granted `cen` cycles per grant (1..255).
- `GAP`, 16: minimum `cen` cycles of CPU ownership between grants (0..255).
- `TIMEOUT`, 255: `cen` cycles to wait for `busak_n` before flagging an error (1..255).

Ports:
- `clk`  in  1: system clock, the only clock.
- `rst`  in  1: asynchronous, active-high reset.
- `cen`  in  1: Z80 clock enable. All FSM and counter activity is qualified by it.
- `busrq_n`  out  1: to the Z80.
- `busak_n`  in  1: from the Z80.
- `cpu_addr`  in  AW: Z80 A[AW-1:0].
- `cpu_dout`  in  DW: Z80 data out.
- `cpu_we`  in  1: Z80 RAM write strobe (`ram_cs & ~wr_n`).
- `dma_req`  in  1: level request. Held high while the DMA port wants the bus.
- `dma_gnt`  out  1: the DMA port owns the RAM.
- `dma_addr`  in  AW: DMA RAM address.
- `dma_dout`  in  DW: DMA write data.
- `dma_we`  in  1: DMA write strobe. Ignored while `dma_gnt`=0.
- `ram_addr`  out  AW: to RAM.
- `ram_din`  out  DW: to RAM.
- `ram_we`  out  1: to RAM.
- `timeout_err`  out  1: sticky. Cleared only by `rst`.

## Operation
FSM states are IDLE, REQ, GRANT, RELEASE and HOLDOFF. All transitions occur on a `clk` edge with `cen`=1.
- **IDLE:** `busrq_n`=1. If `dma_req`=1, go to REQ.
- **REQ:** `busrq_n`=0. The timeout counter increments each `cen`.
  - `busak_n`=0 sampled: go to GRANT and clear the burst counter.
  - `dma_req`=0: go to RELEASE.
  - Counter reaches TIMEOUT: set `timeout_err` and go to RELEASE.
- **GRANT:** `busrq_n`=0, `dma_gnt`=1. The burst counter increments each `cen`.
  - `dma_req`=0, or the counter reaches MAXBURST: go to RELEASE.
  - `busak_n` rising unexpectedly: go to RELEASE immediately.
- **RELEASE:** `busrq_n`=1, `dma_gnt`=0. Wait for `busak_n`=1, then go to HOLDOFF and clear the gap counter. When GAP=0, go straight to IDLE.
- **HOLDOFF:** `busrq_n`=1. Count GAP `cen` cycles, then go to IDLE. `dma_req` is ignored while counting.
- **RAM mux (combinational):**
  - `dma_gnt`=1: RAM signals = DMA signals.
  - Otherwise: RAM signals = CPU signals, except that `ram_we` is forced to 0 in REQ and RELEASE while `busak_n`=0, so the tri-stated Z80 cannot write.
- **Counters:** 8-bit, saturating. They never wrap.

## Timing
- **Reset values:** `busrq_n`=1, `dma_gnt`=0, `timeout_err`=0, state IDLE, counters 0. `ram_*` follow the CPU inputs. Reset mid-grant releases the bus asynchronously within the same cycle.
- **Request latency:** `dma_req` high to `busrq_n` low takes 1 `cen` cycle.
- **Grant latency:** `busak_n` low to `dma_gnt` high takes 1 `cen` cycle. `dma_gnt` is registered.
- **Release latency:** `dma_req` low to `dma_gnt` low takes 1 `cen` cycle. `busrq_n` rises on the same edge.
- **Simultaneous events in GRANT:** `dma_req` falling and MAXBURST reached on the same edge cause a single RELEASE. No double counting.
- **Simultaneous events in REQ:** timeout and `busak_n`=0 on the same edge give priority to GRANT. The error is not set.
- **`cen` stalled:** state, counters and outputs hold. The RAM mux still tracks its inputs combinationally.

## Structure
- Shared package `jtframe_z80_busarb_pkg` holds:
  - the state enum (3-bit encoding: IDLE=0, REQ=1, GRANT=2, RELEASE=3, HOLDOFF=4);
  - the counter width constant (8).
- The block is a single module. No sub-module.
- The RAM mux stays in the same file as the FSM.
- Instantiated beside `jtframe_ram` in the Z80 subsystem wrapper.

## Test plan
- **Basic grant:** `dma_req`=1, Z80 model acks after 3 `cen` → `busrq_n` low at cen 1, `dma_gnt` high 1 `cen` after ack. DMA write 0xA5 @0x123 appears on `ram_*`.
- **Burst cap:** MAXBURST=4, `dma_req` held → `dma_gnt` high exactly 4 `cen`, then `busrq_n`=1. No new `busrq_n` for GAP=16 `cen` after `busak_n` returns high.
- **Timeout:** TIMEOUT=8, `busak_n` stuck high → `timeout_err`=1 after 8 `cen`, `busrq_n`=1. `timeout_err` stays set until `rst`.
- **Abort in REQ:** `dma_req` dropped before ack → no `dma_gnt`. Z80 write 0x5A @0x010 reaches RAM after `busak_n`=1.
- **Async reset mid-GRANT:** `rst` pulsed → `busrq_n`=1 and `dma_gnt`=0 without a clock edge. CPU owns the mux.
- **`cen` gating:** `cen`=0 for 10 clocks during GRANT → burst counter and outputs frozen. Counting resumes on the next `cen`.
